// File: rtl/pwm_multi_ch.sv
//==============================================================================
// Module   : pwm_multi_ch
// Brief    : Multi-channel PWM generator. One shared phase counter drives
//            N_CH duty comparators with per-channel live polarity. It has
//            edge-aligned and center-aligned modes. Period, duty and mode are
//            double-buffered and only take effect at a period boundary.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   sys_clk       in   1           system clock, rising edge
//   sys_rst       in   1           synchronous reset, active-high
//   i_en          in   1           run enable (phase held at 0 while low)
//   i_mode        in   1           0 = edge-aligned, 1 = center-aligned
//   i_period      in   CNT_W       period value P
//   i_duty        in   N_CH*CNT_W  duty per channel, ch k at [k*CNT_W +: CNT_W]
//   i_pol         in   N_CH        per-channel polarity (1 = inverted), live
//   i_load        in   1           strobe capturing i_mode/i_period/i_duty
//   o_pwm         out  N_CH        registered PWM outputs
//   o_period_end  out  1           one-cycle pulse after the last phase
//   o_pending     out  1           captured settings waiting for a boundary
//==============================================================================
`default_nettype none

module pwm_multi_ch #(
    parameter int CNT_W = 8,
    parameter int N_CH  = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  i_en,
    input  logic                  i_mode,
    input  logic [CNT_W-1:0]      i_period,
    input  logic [N_CH*CNT_W-1:0] i_duty,
    input  logic [N_CH-1:0]       i_pol,
    input  logic                  i_load,
    output logic [N_CH-1:0]       o_pwm,
    output logic                  o_period_end,
    output logic                  o_pending
);

    // The phase counter needs one extra bit: a center-aligned period spans
    // 2P phases, which does not fit in CNT_W bits.
    localparam int              c_PH_W   = CNT_W + 1;
    localparam logic [c_PH_W-1:0] c_PH_ZERO = '0;
    localparam logic [c_PH_W-1:0] c_PH_ONE  = c_PH_W'(1);

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [c_PH_W-1:0]       r_ph;

    // Active settings (drive the comparators)
    logic [CNT_W-1:0]        r_period_act;
    logic [N_CH*CNT_W-1:0]   r_duty_act;
    logic                    r_mode_act;

    // Pending (shadow) settings, captured by i_load
    logic [CNT_W-1:0]        r_period_pnd;
    logic [N_CH*CNT_W-1:0]   r_duty_pnd;
    logic                    r_mode_pnd;
    logic                    r_pending;

    // Output registers
    logic [N_CH-1:0]         r_pwm;
    logic                    r_period_end;

    //--------------------------------------------------------------------------
    // Period geometry
    //--------------------------------------------------------------------------
    logic [c_PH_W-1:0]       w_period_ext;  // P zero-extended to phase width
    logic [c_PH_W-1:0]       w_period_x2;   // 2P
    logic [c_PH_W-1:0]       w_last_ph;     // L-1
    logic                    w_at_last;
    logic                    w_boundary;
    logic [c_PH_W-1:0]       w_ph_nxt;

    assign w_period_ext = {1'b0, r_period_act};
    assign w_period_x2  = {r_period_act, 1'b0};

    // Last phase of the period:
    //   edge   : L = P+1          -> L-1 = P
    //   center : L = 2P (1 if P=0) -> L-1 = 2P-1 (0 if P=0)
    always_comb begin
        w_last_ph = w_period_ext;
        if (r_mode_act) begin
            if (r_period_act == '0) begin
                w_last_ph = c_PH_ZERO;
            end else begin
                w_last_ph = w_period_x2 - c_PH_ONE;
            end
        end
    end

    // Active settings only change while ph wraps to 0, so ph never exceeds
    // the last phase; ">=" merely makes the wrap self-healing.
    assign w_at_last  = (r_ph >= w_last_ph);

    // Every disabled cycle is treated as a boundary so that pending settings
    // drop straight into the active set while the generator is stopped.
    assign w_boundary = !i_en || w_at_last;

    always_comb begin
        w_ph_nxt = r_ph + c_PH_ONE;
        if (w_boundary) begin
            w_ph_nxt = c_PH_ZERO;
        end
    end

    //--------------------------------------------------------------------------
    // Compare value: a ramp in edge mode, a triangle 0..P..1 in center mode.
    // Kept at phase width so the duty compare needs no truncation.
    //--------------------------------------------------------------------------
    logic [c_PH_W-1:0]       w_cnt;

    always_comb begin
        w_cnt = r_ph;
        if (r_mode_act && (r_ph > w_period_ext)) begin
            w_cnt = w_period_x2 - r_ph;
        end
    end

    //--------------------------------------------------------------------------
    // Per-channel comparators
    //--------------------------------------------------------------------------
    logic [N_CH-1:0]         w_raw;
    logic [N_CH-1:0]         w_pwm_nxt;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic [CNT_W-1:0] w_duty_k;
            assign w_duty_k = r_duty_act[k*CNT_W +: CNT_W];
            // duty 0 -> never high; duty > P -> always high
            assign w_raw[k] = (w_cnt < {1'b0, w_duty_k});
        end
    endgenerate

    // Polarity is live; when disabled every channel sits at its inactive level.
    assign w_pwm_nxt = i_en ? (w_raw ^ i_pol) : i_pol;

    //--------------------------------------------------------------------------
    // Phase counter and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ph         <= c_PH_ZERO;
            r_pwm        <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_ph         <= i_en ? w_ph_nxt : c_PH_ZERO;
            r_pwm        <= w_pwm_nxt;
            r_period_end <= i_en && w_at_last;
        end
    end

    //--------------------------------------------------------------------------
    // Double buffering
    //   load outside a boundary : capture into pending, raise pending
    //   load on a boundary      : write straight into active, pending clears
    //   boundary, no load       : promote pending into active if set
    // The pending registers are also reset so that nothing loaded before a
    // reset can ever surface afterwards.
    //--------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_period_act <= '1;
            r_duty_act   <= '0;
            r_mode_act   <= 1'b0;
            r_period_pnd <= '1;
            r_duty_pnd   <= '0;
            r_mode_pnd   <= 1'b0;
            r_pending    <= 1'b0;
        end else if (i_load) begin
            if (w_boundary) begin
                r_period_act <= i_period;
                r_duty_act   <= i_duty;
                r_mode_act   <= i_mode;
                r_pending    <= 1'b0;
            end else begin
                r_period_pnd <= i_period;
                r_duty_pnd   <= i_duty;
                r_mode_pnd   <= i_mode;
                r_pending    <= 1'b1;
            end
        end else if (w_boundary && r_pending) begin
            r_period_act <= r_period_pnd;
            r_duty_act   <= r_duty_pnd;
            r_mode_act   <= r_mode_pnd;
            r_pending    <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign o_pwm        = r_pwm;
    assign o_period_end = r_period_end;
    assign o_pending    = r_pending;

endmodule

`default_nettype wire
